fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch queue between the instruction-memory fetch stage and decode. Captures each fetched {PC, instruction} pair into a small circular buffer, decouples fetch from decode back-pressure, and presents the head entry to decode with its RISC-V fields pre-split. Detects the all-zero end-of-trace word and halts fetch. Supports a single-cycle flush for redirects.

## Interface
- DEPTH, 4, number of entries; power of two, minimum 2
- PC_WIDTH, 12, PC width, matching the byte-addressed instruction ROM
- INSTR_WIDTH, 32, instruction width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries and of halted
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  queue accepts an entry this cycle
- in_pc  in  PC_WIDTH  PC of the fetched word
- in_instr  in  INSTR_WIDTH  fetched instruction, big-endian assembled
- out_valid  out  1  head entry is valid
- out_ready  in  1  decode consumes the head this cycle
- out_pc  out  PC_WIDTH  head PC
- out_instr  out  INSTR_WIDTH  head instruction
- out_opcode  out  7  instr[6:0]
- out_rd  out  5  instr[11:7]
- out_funct3  out  3  instr[14:12]
- out_rs1  out  5  instr[19:15]
- out_rs2  out  5  instr[24:20]
- out_funct7  out  7  instr[31:25]
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
- halted  out  1  end-of-trace word seen

## Operation
- Push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != DEPTH) && !halted; registered state only, never depends on in_valid, in_instr, or out_ready.
- out_valid = (count != 0). Head fields are driven from the stored entry at the read pointer. Field outputs are valid only while out_valid is 1.
- Push of in_instr == 0: entry is not stored; halted is set to 1 next edge; the write pointer and count are unchanged by that push.
- Push and pop in the same cycle: both take effect; count is unchanged.
- Full and out_ready in the same cycle: pop only; no push, because in_ready is already 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- flush has priority over push and pop in that cycle. Next edge: pointers = 0, count = 0, halted = 0. A push in the flush cycle is discarded.
- While halted, entries already queued continue to drain normally.
- Fetch holds in_pc and in_instr and stalls its PC while in_ready is 0.

## Timing
- Reset (async, rst_n = 0): pointers 0, count 0, halted 0, all storage 0. Therefore out_valid = 0, in_ready = 1, and all out_* fields = 0.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Push-to-out_valid latency is 1 cycle. There is no same-cycle bypass.
- Sustained throughput is 1 entry per cycle with push and pop concurrent.
- halted rises 1 cycle after the zero-word push. in_ready falls in the same cycle as halted rises.
- After flush deasserts, in_ready = 1 in the next cycle.

## Structure
- Shared package cpu_pkg holds: PC_WIDTH, INSTR_WIDTH, field bit-position constants (OPCODE_LSB, RD_LSB, FUNCT3_LSB, RS1_LSB, RS2_LSB, FUNCT7_LSB), and an END_OF_TRACE constant = 32'h0000_0000.
- Sub-module instr_predecode: purely combinational split of one instruction into opcode, rd, funct3, rs1, rs2, funct7. It is instantiated on the head entry and reused later by decode.
- Storage: DEPTH × (PC_WIDTH + INSTR_WIDTH) register array, plus read pointer, write pointer, and count registers.

## Test plan
- Reset, then push PC = 0x000, instr 0x00500093 → next cycle out_valid = 1, out_pc = 0x000, out_opcode = 0x13, out_rd = 1, out_rs1 = 0, count = 1.
- Push 4 entries with out_ready = 0 (DEPTH = 4) → count = 4, in_ready = 0. A 5th in_valid is ignored. Set out_ready = 1 → entries emerge in PC order 0x000, 0x004, 0x008, 0x00C.
- Continuous push and pop for 10 cycles from count = 2 → count stays 2. Pointers wrap with no loss or duplication; PCs are strictly +4.
- Push instr 0x00000000 at PC 0x030 with 2 entries queued → halted = 1 and in_ready = 0 next cycle. The 2 entries drain, then out_valid = 0. The zero word is never output.
- Full queue, then assert flush with in_valid = 1 and out_ready = 1 → next cycle count = 0, out_valid = 0, halted = 0, in_ready = 1, and no pop was accepted by decode.
- Drop rst_n between clock edges with count = 3 → out_valid = 0 and count = 0 immediately. After release, a push yields out_valid = 1 one cycle later.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// cpu_pkg: constants and types shared by the fetch queue, its predecoder and
// (later) the decode stage.
//   PC_WIDTH / INSTR_WIDTH : datapath widths
//   *_LSB                  : RISC-V base-format field positions
//   END_OF_TRACE           : instruction word that ends the fetched trace
//   fq_entry_t             : one queued {pc, instr} pair
package cpu_pkg;
   localparam int PC_WIDTH    = 12;
   localparam int INSTR_WIDTH = 32;

   localparam int OPCODE_LSB = 0;
   localparam int RD_LSB     = 7;
   localparam int FUNCT3_LSB = 12;
   localparam int RS1_LSB    = 15;
   localparam int RS2_LSB    = 20;
   localparam int FUNCT7_LSB = 25;

   localparam logic [INSTR_WIDTH-1:0] END_OF_TRACE = 32'h0000_0000;

   typedef struct packed {
      logic [PC_WIDTH-1:0]    pc;
      logic [INSTR_WIDTH-1:0] instr;
   } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side push handshake, decode-side pop handshake with
// predecoded head fields, and queue status.
//   master : the fetch/decode environment (drives in_*, out_ready)
//   slave  : the queue itself
interface fetch_queue_if #(parameter int DEPTH = 4);
   import cpu_pkg::*;
   localparam int CW = $clog2(DEPTH) + 1;

   logic                   in_valid;
   logic                   in_ready;
   logic [PC_WIDTH-1:0]    in_pc;
   logic [INSTR_WIDTH-1:0] in_instr;

   logic                   out_valid;
   logic                   out_ready;
   logic [PC_WIDTH-1:0]    out_pc;
   logic [INSTR_WIDTH-1:0] out_instr;
   logic [6:0]             out_opcode;
   logic [4:0]             out_rd;
   logic [2:0]             out_funct3;
   logic [4:0]             out_rs1;
   logic [4:0]             out_rs2;
   logic [6:0]             out_funct7;

   logic [CW-1:0]          count;
   logic                   halted;

   modport master (
      output in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_opcode, out_rd,
             out_funct3, out_rs1, out_rs2, out_funct7, count, halted
   );

   modport slave (
      input  in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_opcode, out_rd,
             out_funct3, out_rs1, out_rs2, out_funct7, count, halted
   );
endinterface

// File: rtl/instr_predecode.sv
// instr_predecode: purely combinational split of one RISC-V instruction
// into its base-format fields. Shared between the fetch queue head and decode.
//   instr  : instruction word
//   opcode, rd, funct3, rs1, rs2, funct7 : extracted fields
module instr_predecode
   import cpu_pkg::*;
(
   input  logic [INSTR_WIDTH-1:0] instr,
   output logic [6:0]             opcode,
   output logic [4:0]             rd,
   output logic [2:0]             funct3,
   output logic [4:0]             rs1,
   output logic [4:0]             rs2,
   output logic [6:0]             funct7
);
   assign opcode = instr[OPCODE_LSB +: 7];
   assign rd     = instr[RD_LSB     +: 5];
   assign funct3 = instr[FUNCT3_LSB +: 3];
   assign rs1    = instr[RS1_LSB    +: 5];
   assign rs2    = instr[RS2_LSB    +: 5];
   assign funct7 = instr[FUNCT7_LSB +: 7];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of {pc, instr} between fetch and decode.
//   clk, rst_n : clock, async active-low reset (clears storage too)
//   flush      : synchronous clear of entries and halted; beats push/pop
//   bus        : slave side of fetch_queue_if (push, pop, head fields, status)
// An all-zero instruction word is never stored; pushing it latches halted,
// which blocks further pushes while already-queued entries drain.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   fetch_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fq_entry_t     mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count_q;
   logic          halted_q;

   logic push, pop, eot, store;
   fq_entry_t head;

   // Ready is purely registered so fetch can use it without a comb loop.
   assign bus.in_ready  = (count_q != CW'(DEPTH)) && !halted_q;
   assign bus.out_valid = (count_q != '0);
   assign bus.count     = count_q;
   assign bus.halted    = halted_q;

   assign push  = bus.in_valid && bus.in_ready && !flush;
   assign pop   = bus.out_valid && bus.out_ready && !flush;
   assign eot   = (bus.in_instr == END_OF_TRACE);
   assign store = push && !eot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= '0;
         halted_q <= 1'b0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         // Pointers wrap for free: DEPTH is a power of two.
         if (store) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_q + {{(CW-1){1'b0}}, store} - {{(CW-1){1'b0}}, pop};
         if (push && eot) halted_q <= 1'b1;
      end
   end

   // Storage is reset so the head fields read as zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (store) begin
         mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
      end
   end

   assign head          = mem[rd_ptr];
   assign bus.out_pc    = head.pc;
   assign bus.out_instr = head.instr;

   instr_predecode u_predecode (
      .instr  (head.instr),
      .opcode (bus.out_opcode),
      .rd     (bus.out_rd),
      .funct3 (bus.out_funct3),
      .rs1    (bus.out_rs1),
      .rs2    (bus.out_rs2),
      .funct7 (bus.out_funct7)
   );
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   fetch_queue_if #(.DEPTH(DEPTH)) bus ();

   fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain FIFO of {pc, instr} plus the halted flag.
   logic [43:0] q[$];
   bit          m_halt;

   function automatic bit m_ready();
      return (q.size() != DEPTH) && !m_halt;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_halt = 1'b0;
      end else if (flush) begin
         q.delete();
         m_halt = 1'b0;
      end else begin
         bit do_push;
         do_push = bus.in_valid && m_ready();
         if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
         if (do_push) begin
            if (bus.in_instr == 32'd0) m_halt = 1'b1;
            else q.push_back({bus.in_pc, bus.in_instr});
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         logic [31:0] h;
         check("in_ready",  bus.in_ready,  m_ready());
         check("out_valid", bus.out_valid, q.size() != 0);
         check("count",     bus.count,     q.size());
         check("halted",    bus.halted,    m_halt);
         if (q.size() != 0) begin
            h = q[0][31:0];
            check("out_pc",     bus.out_pc,     q[0][43:32]);
            check("out_instr",  bus.out_instr,  h);
            check("out_opcode", bus.out_opcode, h[6:0]);
            check("out_rd",     bus.out_rd,     h[11:7]);
            check("out_funct3", bus.out_funct3, h[14:12]);
            check("out_rs1",    bus.out_rs1,    h[19:15]);
            check("out_rs2",    bus.out_rs2,    h[24:20]);
            check("out_funct7", bus.out_funct7, h[31:25]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_instr(input logic [11:0] pc);
      return {pc, 20'h00013};
   endfunction

   task automatic push_n(input int n, input logic [11:0] pc0);
      for (int i = 0; i < n; i++) begin
         bus.in_valid = 1'b1;
         bus.in_pc    = pc0 + 12'(4 * i);
         bus.in_instr = mk_instr(bus.in_pc);
         step();
      end
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [11:0] pc;
      bit acc;
      bus.in_valid  = 1'b0;
      bus.in_pc     = '0;
      bus.in_instr  = '0;
      bus.out_ready = 1'b0;
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_count",     bus.count,     0);
      check("rst_halted",    bus.halted,    0);
      check("rst_out_pc",    bus.out_pc,    0);
      check("rst_out_instr", bus.out_instr, 0);
      check("rst_opcode",    bus.out_opcode, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // First push and field split.
      bus.in_valid = 1'b1; bus.in_pc = 12'h000; bus.in_instr = 32'h00500093;
      step();
      bus.in_valid = 1'b0;
      check("t1_out_valid", bus.out_valid, 1);
      check("t1_out_pc",    bus.out_pc,    12'h000);
      check("t1_opcode",    bus.out_opcode, 7'h13);
      check("t1_rd",        bus.out_rd,    5'd1);
      check("t1_rs1",       bus.out_rs1,   5'd0);
      check("t1_count",     bus.count,     1);
      bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;

      // Fill, overfill attempt, then drain in order.
      push_n(4, 12'h000);
      check("t2_count_full", bus.count, 4);
      check("t2_in_ready",   bus.in_ready, 0);
      bus.in_valid = 1'b1; bus.in_pc = 12'h010; bus.in_instr = mk_instr(12'h010);
      step();
      bus.in_valid = 1'b0;
      check("t2_count_still_full", bus.count, 4);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t2_drain_pc", bus.out_pc, 12'(4 * i));
         step();
      end
      bus.out_ready = 1'b0;
      check("t2_empty", bus.out_valid, 0);

      // Sustained concurrent push/pop at count 2.
      push_n(2, 12'h100);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         bus.in_valid = 1'b1;
         bus.in_pc    = 12'h108 + 12'(4 * k);
         bus.in_instr = mk_instr(bus.in_pc);
         step();
         check("t3_count", bus.count, 2);
         check("t3_head_pc", bus.out_pc, 12'h104 + 12'(4 * k));
      end
      bus.in_valid = 1'b0;
      repeat (2) step();
      bus.out_ready = 1'b0;
      check("t3_empty", bus.out_valid, 0);

      // End-of-trace word with two entries queued.
      push_n(2, 12'h028);
      bus.in_valid = 1'b1; bus.in_pc = 12'h030; bus.in_instr = 32'h0;
      step();
      bus.in_valid = 1'b0;
      check("t4_halted",   bus.halted,   1);
      check("t4_in_ready", bus.in_ready, 0);
      check("t4_count",    bus.count,    2);
      bus.out_ready = 1'b1;
      check("t4_drain0", bus.out_pc, 12'h028);
      step();
      check("t4_drain1", bus.out_pc, 12'h02C);
      step();
      bus.out_ready = 1'b0;
      check("t4_empty",      bus.out_valid, 0);
      check("t4_still_halt", bus.halted,    1);
      flush = 1'b1; step(); flush = 1'b0;
      check("t4_unhalt",  bus.halted,   0);
      check("t4_ready",   bus.in_ready, 1);

      // Flush beats push and pop.
      push_n(4, 12'h200);
      check("t5_full", bus.count, 4);
      flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      bus.in_pc = 12'h210; bus.in_instr = mk_instr(12'h210);
      step();
      flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      check("t5_count",     bus.count,     0);
      check("t5_out_valid", bus.out_valid, 0);
      check("t5_halted",    bus.halted,    0);
      check("t5_in_ready",  bus.in_ready,  1);

      // Asynchronous reset between edges.
      push_n(3, 12'h300);
      check("t6_count3", bus.count, 3);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_valid", bus.out_valid, 0);
      check("t6_async_count", bus.count,     0);
      #3 rst_n = 1'b1;
      step();
      bus.in_valid = 1'b1; bus.in_pc = 12'h400; bus.in_instr = mk_instr(12'h400);
      step();
      bus.in_valid = 1'b0;
      check("t6_post_valid", bus.out_valid, 1);
      check("t6_post_pc",    bus.out_pc,    12'h400);
      bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;

      // Randomized traffic; fetch holds its word until accepted.
      pc = 12'h500;
      bus.in_valid = 1'b0;
      for (int c = 0; c < 600; c++) begin
         if (!bus.in_valid) begin
            bus.in_valid = ($urandom % 4) != 0;
            bus.in_pc    = pc;
            bus.in_instr = (($urandom % 60) == 0) ? 32'h0 : ($urandom | 32'h1);
         end
         bus.out_ready = ($urandom % 3) != 0;
         flush = ($urandom % 50) == 0;
         acc = bus.in_valid && m_ready() && !flush;
         step();
         if (flush) begin
            pc = 12'($urandom) & 12'hFFC;
            bus.in_valid = 1'b0;
         end else if (acc) begin
            pc = pc + 12'd4;
            bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1; flush = 1'b0;
      repeat (DEPTH + 1) step();
      check("rnd_drained", bus.out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
